// File: rtl/ntt_vec_scheduler_if.sv
// ntt_vec_scheduler_if
//   Bundles every non-clock signal of the NTT vector scheduler: the host control
//   handshake (start/busy/done/err), the NTT core side, the host RAM port and
//   the shared coefficient RAM port.
//   Modports:
//     slave  - the scheduler itself (consumes start/core/host requests, drives RAM)
//     master - the surrounding wrapper / core / RAM model
//   Parameter KYBER_K must match the scheduler instance; RAM_AW = $clog2(KYBER_K) + 8.
interface ntt_vec_scheduler_if #(
    parameter int KYBER_K = 2
);
    localparam int IDX_W  = $clog2(KYBER_K);
    localparam int RAM_AW = IDX_W + 8;

    // control handshake
    logic              start;
    logic [2:0]        vec_len;
    logic              busy;
    logic              done;
    logic              err;
    // NTT core side
    logic              ntt_enable;
    logic              ntt_done;
    logic [7:0]        core_raddr;
    logic [7:0]        core_waddr;
    logic              core_wen;
    logic [15:0]       core_wdata;
    logic [15:0]       core_rdata;
    // host (AXI loader) side
    logic              host_req;
    logic              host_gnt;
    logic [RAM_AW-1:0] host_addr;
    logic              host_wen;
    logic [15:0]       host_wdata;
    logic [15:0]       host_rdata;
    // shared coefficient RAM
    logic [RAM_AW-1:0] ram_raddr;
    logic [RAM_AW-1:0] ram_waddr;
    logic              ram_wen;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;

    modport slave (
        input  start, vec_len, ntt_done, core_raddr, core_waddr, core_wen, core_wdata,
               host_req, host_addr, host_wen, host_wdata, ram_rdata,
        output busy, done, err, ntt_enable, core_rdata, host_gnt, host_rdata,
               ram_raddr, ram_waddr, ram_wen, ram_wdata
    );

    modport master (
        output start, vec_len, ntt_done, core_raddr, core_waddr, core_wen, core_wdata,
               host_req, host_addr, host_wen, host_wdata, ram_rdata,
        input  busy, done, err, ntt_enable, core_rdata, host_gnt, host_rdata,
               ram_raddr, ram_waddr, ram_wen, ram_wdata
    );
endinterface

// File: rtl/ntt_vec_scheduler.sv
// ntt_vec_scheduler
//   Runs the single-polynomial NTT core over a vector of 1..KYBER_K polynomials
//   stored back to back in one shared coefficient RAM. The core is kicked once
//   per polynomial and its 8-bit coefficient addresses are prefixed with the
//   current polynomial index. The host loader owns the RAM only while idle.
//   Ports:
//     clk      - rising-edge clock
//     reset_n  - synchronous active-low reset (also resets the core externally)
//     bus      - ntt_vec_scheduler_if.slave: start/vec_len/busy/done/err,
//                core enable/done/address/data, host req/gnt/address/data,
//                RAM read/write address, write enable, write/read data
//   Optional feature: define NTT_SCHED_TIMEOUT_EN to enable a per-polynomial
//   watchdog of TIMEOUT_CYCLES; without it err is tied low and RUN waits forever.
module ntt_vec_scheduler #(
    parameter int KYBER_K        = 2,
    parameter int KYBER_N        = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    ntt_vec_scheduler_if.slave bus
);
    localparam int IDX_W  = $clog2(KYBER_K);
    localparam int RAM_AW = IDX_W + 8;

    // The core address width is hard-wired to 8 bits, so only N=256 works.
    if (KYBER_K < 2 || KYBER_K > 4 || KYBER_N != 256 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ntt_vec_scheduler: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_KICK, S_RUN, S_NEXT, S_DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] poly_idx_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [2:0]       n_clamp;
    logic             busy_q;
    logic             done_q;
    logic             kick_q;
    logic             ntt_done_q;
    logic             done_rise;

    // Clamp the requested length; last_d is only used when n_clamp != 0.
    always_comb begin
        n_clamp = (bus.vec_len > 3'(KYBER_K)) ? 3'(KYBER_K) : bus.vec_len;
        last_d  = IDX_W'(n_clamp - 3'd1);
    end

    // The core holds done as a level, so only a fresh rising edge advances RUN.
    assign done_rise = bus.ntt_done & ~ntt_done_q;

`ifdef NTT_SCHED_TIMEOUT_EN
    // Counter is 0 in the first RUN cycle, so matching TIMEOUT_CYCLES-2 puts
    // DONE exactly TIMEOUT_CYCLES cycles after the kick cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 2);
    logic [15:0] tmo_q;
    logic        err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (state_q == S_KICK) begin
            tmo_q <= '0;
        end else if (state_q == S_RUN) begin
            tmo_q <= tmo_q + 16'd1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            poly_idx_q <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            kick_q     <= 1'b0;
            ntt_done_q <= 1'b0;
`ifdef NTT_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            ntt_done_q <= bus.ntt_done;
            done_q     <= 1'b0;
            kick_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        poly_idx_q <= '0;
                        last_q     <= last_d;
`ifdef NTT_SCHED_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                        if (n_clamp == 3'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_KICK;
                            kick_q  <= 1'b1;
                        end
                    end
                end
                S_KICK: state_q <= S_RUN;
                S_RUN: begin
                    if (done_rise) begin
                        state_q <= S_NEXT;
                    end
`ifdef NTT_SCHED_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
`endif
                end
                // One cycle with enable low lets the core drop its done level.
                S_NEXT: begin
                    if (poly_idx_q == last_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        poly_idx_q <= poly_idx_q + 1'b1;
                        state_q    <= S_KICK;
                        kick_q     <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ntt_enable = kick_q;

    // A simultaneous start beats the host so the vector run cannot be raced.
    assign bus.host_gnt   = (state_q == S_IDLE) & bus.host_req & ~bus.start;
    assign bus.core_rdata = bus.ram_rdata;
    assign bus.host_rdata = bus.ram_rdata;

    always_comb begin
        bus.ram_raddr = bus.host_addr;
        bus.ram_waddr = bus.host_addr;
        bus.ram_wdata = bus.host_wdata;
        bus.ram_wen   = 1'b0;
        if (state_q != S_IDLE) begin
            bus.ram_raddr = {poly_idx_q, bus.core_raddr};
            bus.ram_waddr = {poly_idx_q, bus.core_waddr};
            bus.ram_wdata = bus.core_wdata;
            bus.ram_wen   = bus.core_wen;
        end else if (bus.host_gnt) begin
            bus.ram_wen   = bus.host_wen;
        end
    end

    // RAM_AW kept for readability of the address concatenation width.
    if (RAM_AW != IDX_W + 8) begin : g_bad_aw
        $error("ntt_vec_scheduler: RAM_AW inconsistent");
    end
endmodule

// File: tb/tb_ntt_vec_scheduler.sv
module tb_ntt_vec_scheduler;
    localparam int K  = 3;
    localparam int AW = 10;
`ifdef NTT_SCHED_TIMEOUT_EN
    localparam int TMO = 16;
    localparam int LAT = 12;
`else
    localparam int TMO = 16;
    localparam int LAT = 40;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_idx_q[$];

    ntt_vec_scheduler_if #(.KYBER_K(K)) bus ();

    ntt_vec_scheduler #(
        .KYBER_K(K),
        .KYBER_N(256),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // One vector run with a behavioural core: done rises LAT cycles after each
    // kick. sticky keeps done high through NEXT/KICK; poke fires a start mid-run.
    task automatic run_vector(input int len, input bit sticky, input bit poke);
        int n, kicks, cnt, edge_cyc, start_cyc, max_wa;
        bit seen_done;
        n = (len > K) ? K : len;
        for (int i = 0; i < n; i++) exp_idx_q.push_back(i);
        bus.start    = 1'b1;
        bus.vec_len  = 3'(len);
        bus.host_req = 1'b1;
        bus.host_wen = 1'b1;
        #1;
        check_val("start_beats_host", bus.host_gnt, 0);
        start_cyc = cyc;
        step();
        bus.start = 1'b0;
        cnt = -1; kicks = 0; edge_cyc = -100; max_wa = -1; seen_done = 1'b0;
        for (int b = 0; b < 400; b++) begin
            if (bus.ram_wen && bus.busy && int'(bus.ram_waddr) > max_wa) max_wa = int'(bus.ram_waddr);
            if (bus.ntt_enable) begin
                kicks++;
                if (exp_idx_q.size() == 0) check_val("kick_count", kicks, n);
                else check_val("kick_idx", bus.ram_waddr[AW-1:8], exp_idx_q.pop_front());
                check_val("kick_time", cyc, (kicks == 1) ? start_cyc + 1 : edge_cyc + 2);
                cnt = 0;
            end
            if (bus.done) begin
                check_val("done_time", cyc, (n == 0) ? start_cyc + 1 : edge_cyc + 2);
                check_val("sb_empty", exp_idx_q.size(), 0);
                check_val("kicks_total", kicks, n);
                check_val("err_low", bus.err, 0);
                if (n > 0) check_val("waddr_top", max_wa, ((n - 1) << 8) | 255);
                seen_done = 1'b1;
                break;
            end
            if (cnt == 20) begin
                check_val("run_wen", bus.ram_wen, bus.core_wen);
                check_val("run_waddr", bus.ram_waddr, ((kicks - 1) << 8) | bus.core_waddr);
                check_val("run_raddr", bus.ram_raddr, ((kicks - 1) << 8) | bus.core_raddr);
                check_val("run_wdata", bus.ram_wdata, bus.core_wdata);
                check_val("run_host_locked", bus.host_gnt, 0);
                check_val("run_busy", bus.busy, 1);
            end
            // drive the next cycle's inputs
            if (!sticky && bus.ntt_done) bus.ntt_done = 1'b0;
            if (sticky && cnt == 2) bus.ntt_done = 1'b0;
            if (poke && kicks == 1) bus.start = (cnt == 10);
            if (cnt >= 0) begin
                cnt++;
                bus.core_waddr = (cnt >= 37) ? 8'hFF : 8'(cnt * 5);
                bus.core_raddr = 8'(255 - cnt);
                bus.core_wen   = (cnt >= 37) ? 1'b1 : cnt[0];
                bus.core_wdata = 16'(cnt * 7 + kicks);
                if (cnt == LAT) begin
                    bus.ntt_done = 1'b1;
                    bus.core_wen = 1'b0;
                    edge_cyc     = cyc;
                    cnt          = -1;
                end
            end
            step();
        end
        check_val("done_seen", seen_done, 1);
        bus.ntt_done = 1'b0;
        bus.core_wen = 1'b0;
        bus.start    = 1'b0;
        exp_idx_q.delete();
        step();
        check_val("post_busy", bus.busy, 0);
        check_val("post_host_gnt", bus.host_gnt, 1);
        check_val("post_host_wen", bus.ram_wen, 1);
        check_val("post_host_addr", bus.ram_waddr, bus.host_addr);
        bus.host_req = 1'b0;
        bus.host_wen = 1'b0;
        step();
    endtask

`ifdef NTT_SCHED_TIMEOUT_EN
    task automatic run_timeout();
        int k;
        bit seen;
        k = -1000; seen = 1'b0;
        bus.ntt_done = 1'b0;
        bus.start    = 1'b1;
        bus.vec_len  = 3'd1;
        step();
        bus.start = 1'b0;
        for (int b = 0; b < 100; b++) begin
            if (bus.ntt_enable) k = cyc;
            if (bus.done) begin
                check_val("tmo_done_time", cyc, k + TMO);
                check_val("tmo_err", bus.err, 1);
                seen = 1'b1;
                break;
            end
            step();
        end
        check_val("tmo_seen", seen, 1);
        step();
        check_val("tmo_err_sticky", bus.err, 1);
        check_val("tmo_busy", bus.busy, 0);
        bus.start   = 1'b1;
        bus.vec_len = 3'd0;
        step();
        bus.start = 1'b0;
        check_val("tmo_err_cleared", bus.err, 0);
        check_val("tmo_zero_done", bus.done, 1);
        step();
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.vec_len    = 3'd0;
        bus.ntt_done   = 1'b0;
        bus.core_raddr = 8'd0;
        bus.core_waddr = 8'd0;
        bus.core_wen   = 1'b0;
        bus.core_wdata = 16'd0;
        bus.host_req   = 1'b0;
        bus.host_addr  = 10'h2AB;
        bus.host_wen   = 1'b0;
        bus.host_wdata = 16'hBEEF;
        bus.ram_rdata  = 16'h1234;
        repeat (3) step();
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_err", bus.err, 0);
        check_val("rst_enable", bus.ntt_enable, 0);
        reset_n = 1'b1;
        step();

        // idle host path
        bus.host_req = 1'b1;
        bus.host_wen = 1'b1;
        #1;
        check_val("host_gnt", bus.host_gnt, 1);
        check_val("host_ram_wen", bus.ram_wen, 1);
        check_val("host_ram_waddr", bus.ram_waddr, 10'h2AB);
        check_val("host_ram_raddr", bus.ram_raddr, 10'h2AB);
        check_val("host_ram_wdata", bus.ram_wdata, 16'hBEEF);
        check_val("core_rdata", bus.core_rdata, 16'h1234);
        check_val("host_rdata", bus.host_rdata, 16'h1234);
        bus.host_req = 1'b0;
        #1;
        check_val("nogrant_wen", bus.ram_wen, 0);
        bus.host_wen = 1'b0;
        step();

        run_vector(2, 1'b0, 1'b1);
        run_vector(7, 1'b1, 1'b0);
        run_vector(0, 1'b0, 1'b0);

        // reset in the middle of RUN
        bus.start   = 1'b1;
        bus.vec_len = 3'd2;
        step();
        bus.start = 1'b0;
        repeat (8) step();
        check_val("mid_busy_before", bus.busy, 1);
        reset_n      = 1'b0;
        bus.host_req = 1'b1;
        step();
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_enable", bus.ntt_enable, 0);
        check_val("mid_rst_err", bus.err, 0);
        check_val("mid_rst_gnt", bus.host_gnt, 1);
        bus.host_req = 1'b0;
        #1;
        check_val("mid_rst_gnt_off", bus.host_gnt, 0);
        reset_n = 1'b1;
        step();

        run_vector(1, 1'b0, 1'b0);
`ifdef NTT_SCHED_TIMEOUT_EN
        run_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
